brush_stroke_writer: RTL and testbench

Converts touch samples into square brush stamps for the 1-bit frame buffer. Sits directly upstream of the graphic controller, which accepts pixel writes. For each accepted touch point it walks every pixel of a clipped BRUSH_SIZE×BRUSH_SIZE square centred on the point. It drives the controller's `pixel_col`, `pixel_row`, `write_pixel` and `bw_pixel_color` inputs at a fixed 2-cycle cadence.

---
 rtl/brush_stroke_writer_if.sv | 34 +++
 rtl/brush_stroke_writer.sv | 157 +++++++++++++++
 tb/tb_brush_stroke_writer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brush_stroke_writer_if.sv
// Touch-in / pixel-out bundle between the touch front end, brush_stroke_writer and the
// graphic controller. The erase line exists only when BRUSH_ERASE_EN is defined.
interface brush_stroke_writer_if;
    logic       gc_initialized;
    logic       touch_valid;
    logic       touch_ready;
    logic [8:0] touch_x;
    logic [7:0] touch_y;
`ifdef BRUSH_ERASE_EN
    logic       erase;
`endif
    logic [8:0] pixel_col;
    logic [7:0] pixel_row;
    logic       write_pixel;
    logic       bw_pixel_color;
    logic       busy;
    logic       done;

    modport master (
`ifdef BRUSH_ERASE_EN
        output erase,
`endif
        output gc_initialized, touch_valid, touch_x, touch_y,
        input  touch_ready, pixel_col, pixel_row, write_pixel, bw_pixel_color, busy, done
    );

    modport slave (
`ifdef BRUSH_ERASE_EN
        input  erase,
`endif
        input  gc_initialized, touch_valid, touch_x, touch_y,
        output touch_ready, pixel_col, pixel_row, write_pixel, bw_pixel_color, busy, done
    );
endinterface

// File: rtl/brush_stroke_writer.sv
// Stamps a clipped BRUSH_SIZE x BRUSH_SIZE square per accepted touch, one pixel write every
// two cycles. Define BRUSH_ERASE_EN to add the erase input (stamp colour = ~erase).
module brush_stroke_writer #(
    parameter int unsigned BRUSH_SIZE = 5,
    parameter int unsigned COL_NUM    = 320,
    parameter int unsigned ROW_NUM    = 240
) (
    input logic                   clk,
    input logic                   reset,
    brush_stroke_writer_if.slave  bus
);

    localparam logic [9:0] Rad    = 10'((BRUSH_SIZE - 1) / 2);
    localparam logic [9:0] ColMax = 10'(COL_NUM - 1);
    localparam logic [9:0] RowMax = 10'(ROW_NUM - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StHold} state_e;

    state_e     state_q, state_d;
    logic [8:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d, col_q, col_d;
    logic [7:0] y_q, y_d, y0_q, y0_d, y1_q, y1_d, row_q, row_d;
    logic       write_q, write_d;
    logic       color_q, color_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       ready;
    logic       accept;
    logic       ink;
    logic [9:0] x_ext, y_ext;
    logic [8:0] x0_c, x1_c;
    logic [7:0] y0_c, y1_c;

    assign ready  = (state_q == StIdle) && bus.gc_initialized;
    assign accept = ready && bus.touch_valid
                    && ({1'b0, bus.touch_x} < 10'(COL_NUM))
                    && ({2'b0, bus.touch_y} < 10'(ROW_NUM));

`ifdef BRUSH_ERASE_EN
    assign ink = ~bus.erase;
`else
    assign ink = 1'b1;
`endif

    // Clip window in 10 bits so x+R cannot wrap before the compare.
    assign x_ext = {1'b0, x_q};
    assign y_ext = {2'b0, y_q};
    assign x0_c  = (x_ext < Rad) ? 9'd0 : 9'(x_ext - Rad);
    assign x1_c  = (x_ext + Rad > ColMax) ? 9'(ColMax) : 9'(x_ext + Rad);
    assign y0_c  = (y_ext < Rad) ? 8'd0 : 8'(y_ext - Rad);
    assign y1_c  = (y_ext + Rad > RowMax) ? 8'(RowMax) : 8'(y_ext + Rad);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        col_d   = col_q;
        row_d   = row_q;
        color_d = color_q;
        busy_d  = busy_q;
        write_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    x_d     = bus.touch_x;
                    y_d     = bus.touch_y;
                    color_d = ink;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                x0_d    = x0_c;
                x1_d    = x1_c;
                y0_d    = y0_c;
                y1_d    = y1_c;
                col_d   = x0_c;
                row_d   = y0_c;
                write_d = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StHold;
            end
            StHold: begin
                // Coordinates only advance here, after the controller has sampled them.
                if (col_q == x1_q && row_q == y1_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    color_d = 1'b0;
                    state_d = StIdle;
                end else if (col_q == x1_q) begin
                    col_d   = x0_q;
                    row_d   = row_q + 8'd1;
                    write_d = 1'b1;
                    state_d = StWrite;
                end else begin
                    col_d   = col_q + 9'd1;
                    write_d = 1'b1;
                    state_d = StWrite;
                end
            end
            default: begin
                busy_d  = 1'b0;
                color_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            write_q <= 1'b0;
            color_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            write_q <= write_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.touch_ready    = ready;
    assign bus.pixel_col      = col_q;
    assign bus.pixel_row      = row_q;
    assign bus.write_pixel    = write_q;
    assign bus.bw_pixel_color = color_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_brush_stroke_writer.sv
// Bench for brush_stroke_writer: directed stamps with literal expectations, then random
// touches checked every cycle against a pixel-list model of each stamp.
module tb_brush_stroke_writer;

    localparam int BS   = 3;
    localparam int COLS = 320;
    localparam int ROWS = 240;
    localparam int RAD  = (BS - 1) / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    brush_stroke_writer_if bus();

    brush_stroke_writer #(
        .BRUSH_SIZE(BS),
        .COL_NUM   (COLS),
        .ROW_NUM   (ROWS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Model state: pixel list of the stamp in flight and the cycle its touch was presented.
    bit m_active = 1'b0;
    int m_t, m_n, m_color;
    int m_cols[$];
    int m_rows[$];

    // Log of observed strobes/dones used by the directed checks.
    int lg_col[$], lg_row[$], lg_cyc[$], lg_clr[$], lg_done[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        lg_col.delete(); lg_row.delete(); lg_cyc.delete(); lg_clr.delete(); lg_done.delete();
    endtask

    always @(negedge clk) begin
        int d;
        if (reset) begin
            m_active = 1'b0;
        end else begin
            d = cyc - m_t;
            if (bus.write_pixel) begin
                lg_col.push_back(int'(bus.pixel_col));
                lg_row.push_back(int'(bus.pixel_row));
                lg_cyc.push_back(cyc);
                lg_clr.push_back(int'(bus.bw_pixel_color));
            end
            if (bus.done) lg_done.push_back(cyc);

            if (m_active && d == 2 * m_n + 2) begin
                check("done_pulse", int'(bus.done), 1);
                m_active = 1'b0;
            end else begin
                check("done_quiet", int'(bus.done), 0);
            end

            if (m_active) begin
                check("busy_stamp", int'(bus.busy), 1);
                check("ready_stamp", int'(bus.touch_ready), 0);
                check("color_stamp", int'(bus.bw_pixel_color), m_color);
                if (d >= 2 && d % 2 == 0) begin
                    check("strobe", int'(bus.write_pixel), 1);
                    check("pixel_col", int'(bus.pixel_col), m_cols[(d - 2) / 2]);
                    check("pixel_row", int'(bus.pixel_row), m_rows[(d - 2) / 2]);
                end else begin
                    check("no_strobe", int'(bus.write_pixel), 0);
                end
            end else begin
                check("busy_idle", int'(bus.busy), 0);
                check("ready_idle", int'(bus.touch_ready), int'(bus.gc_initialized));
                check("write_idle", int'(bus.write_pixel), 0);
                check("color_idle", int'(bus.bw_pixel_color), 0);
            end

            if (!m_active && bus.gc_initialized && bus.touch_valid
                && int'(bus.touch_x) < COLS && int'(bus.touch_y) < ROWS) begin
                int x, y, xlo, xhi, ylo, yhi;
                x = int'(bus.touch_x);
                y = int'(bus.touch_y);
                xlo = (x - RAD < 0) ? 0 : x - RAD;
                xhi = (x + RAD > COLS - 1) ? COLS - 1 : x + RAD;
                ylo = (y - RAD < 0) ? 0 : y - RAD;
                yhi = (y + RAD > ROWS - 1) ? ROWS - 1 : y + RAD;
                m_cols.delete();
                m_rows.delete();
                for (int r = ylo; r <= yhi; r++)
                    for (int c = xlo; c <= xhi; c++) begin
                        m_cols.push_back(c);
                        m_rows.push_back(r);
                    end
                m_n = m_cols.size();
`ifdef BRUSH_ERASE_EN
                m_color = bus.erase ? 0 : 1;
`else
                m_color = 1;
`endif
                m_t = cyc;
                m_active = 1'b1;
            end
        end
    end

    task automatic touch_once(input int x, input int y, input int er, output int t);
        @(posedge clk); #1;
        bus.touch_valid = 1'b1;
        bus.touch_x = 9'(x);
        bus.touch_y = 8'(y);
`ifdef BRUSH_ERASE_EN
        bus.erase = er[0];
`endif
        t = cyc;
        @(posedge clk); #1;
        bus.touch_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int er;
        int edge_x[7];
        int edge_y[7];
        edge_x = '{0, 1, 2, 318, 319, 320, 511};
        edge_y = '{0, 1, 2, 238, 239, 240, 255};
        er = 0;

        bus.gc_initialized = 1'b0;
        bus.touch_valid = 1'b0;
        bus.touch_x = '0;
        bus.touch_y = '0;
`ifdef BRUSH_ERASE_EN
        bus.erase = 1'b0;
`endif
        wait_cycles(2);
        check("rst_write", int'(bus.write_pixel), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_col", int'(bus.pixel_col), 0);
        check("rst_row", int'(bus.pixel_row), 0);
        reset = 1'b0;
        check("rst_ready_nogc", int'(bus.touch_ready), 0);
        bus.gc_initialized = 1'b1;
        #1;
        check("ready_gc", int'(bus.touch_ready), 1);
        wait_cycles(2);

        // Centre stamp
        clear_logs();
        touch_once(100, 50, 0, t);
        wait_cycles(24);
        check("ctr_count", lg_col.size(), 9);
        if (lg_col.size() == 9) begin
            check("ctr_first_col", lg_col[0], 99);
            check("ctr_first_row", lg_row[0], 49);
            check("ctr_p1_col", lg_col[1], 100);
            check("ctr_p3_col", lg_col[3], 99);
            check("ctr_p3_row", lg_row[3], 50);
            check("ctr_last_col", lg_col[8], 101);
            check("ctr_last_row", lg_row[8], 51);
            check("ctr_color", lg_clr[0], 1);
            for (int k = 0; k < 9; k++) check("ctr_cadence", lg_cyc[k], t + 2 + 2 * k);
        end
        check("ctr_done_n", lg_done.size(), 1);
        if (lg_done.size() == 1) check("ctr_done_t", lg_done[0], t + 20);

        // Top-left clip
        clear_logs();
        touch_once(0, 0, 0, t);
        wait_cycles(14);
        check("tl_count", lg_col.size(), 4);
        if (lg_col.size() == 4) begin
            check("tl_c0", lg_col[0], 0); check("tl_r0", lg_row[0], 0);
            check("tl_c1", lg_col[1], 1); check("tl_r1", lg_row[1], 0);
            check("tl_c2", lg_col[2], 0); check("tl_r2", lg_row[2], 1);
            check("tl_c3", lg_col[3], 1); check("tl_r3", lg_row[3], 1);
        end
        check("tl_done_n", lg_done.size(), 1);
        if (lg_done.size() == 1) check("tl_done_t", lg_done[0], t + 10);

        // Bottom-right clip
        clear_logs();
        touch_once(319, 239, 0, t);
        wait_cycles(14);
        check("br_count", lg_col.size(), 4);
        if (lg_col.size() == 4) begin
            check("br_c0", lg_col[0], 318); check("br_r0", lg_row[0], 238);
            check("br_c3", lg_col[3], 319); check("br_r3", lg_row[3], 239);
        end

        // Rejections: out of range, controller not initialised
        clear_logs();
        touch_once(320, 10, 0, t);
        touch_once(10, 240, 0, t);
        wait_cycles(10);
        bus.gc_initialized = 1'b0;
        touch_once(50, 50, 0, t);
        wait_cycles(10);
        bus.gc_initialized = 1'b1;
        check("rej_strobes", lg_col.size(), 0);
        check("rej_dones", lg_done.size(), 0);

        // Second touch three cycles into a stamp is ignored
        clear_logs();
        touch_once(100, 50, 0, t);
        wait_cycles(2);
        bus.touch_valid = 1'b1;
        bus.touch_x = 9'd200;
        bus.touch_y = 8'd100;
        wait_cycles(1);
        bus.touch_valid = 1'b0;
        wait_cycles(24);
        check("busy_ign_count", lg_col.size(), 9);
        check("busy_ign_done", lg_done.size(), 1);

        // Async reset at the 4th strobe
        clear_logs();
        touch_once(30, 30, 0, t);
        wait_cycles(7);
        check("pre_rst_strobe", int'(bus.write_pixel), 1);
        reset = 1'b1;
        #1;
        check("arst_write", int'(bus.write_pixel), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_col", int'(bus.pixel_col), 0);
        check("arst_row", int'(bus.pixel_row), 0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(20);
        check("arst_no_done", lg_done.size(), 0);
        clear_logs();
        touch_once(30, 30, 0, t);
        wait_cycles(24);
        check("post_rst_count", lg_col.size(), 9);
        check("post_rst_done_n", lg_done.size(), 1);
        if (lg_done.size() == 1) check("post_rst_done_t", lg_done[0], t + 20);

        // Colour select
        clear_logs();
        touch_once(10, 10, 1, t);
        wait_cycles(24);
        check("clr_count", lg_col.size(), 9);
`ifdef BRUSH_ERASE_EN
        if (lg_clr.size() > 0) check("erase_color", lg_clr[0], 0);
`else
        if (lg_clr.size() > 0) check("ink_color", lg_clr[0], 1);
`endif

        // Random touches; the negedge model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset = (i == 1500);
            bus.touch_valid = ($urandom % 3 == 0);
            bus.gc_initialized = ($urandom % 10 != 0);
            bus.touch_x = ($urandom % 4 == 0) ? 9'(edge_x[$urandom % 7])
                                              : 9'($urandom_range(0, 330));
            bus.touch_y = ($urandom % 4 == 0) ? 8'(edge_y[$urandom % 7])
                                              : 8'($urandom_range(0, 250));
            er = int'($urandom % 2);
`ifdef BRUSH_ERASE_EN
            bus.erase = er[0];
`endif
        end
        reset = 1'b0;
        bus.touch_valid = 1'b0;
        bus.gc_initialized = 1'b1;
        wait_cycles(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
